// File: rtl/uart_cmd_sequencer_if.sv
// Bundle between the UART command sequencer, the control unit and the UART TX/RX engines.
// The slave modport is the sequencer's view; the master modport is the view of its surroundings.
interface uart_cmd_sequencer_if;
    logic [2:0]  uartc;
    logic [31:0] cmd_data;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_busy;
    logic        rdy;
    logic        state;
    logic [31:0] rcv_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] baud_div;
    logic        tx_empty;
    logic        tx_overflow;
    logic        rx_overrun;

    modport slave (
        input  uartc, cmd_data, rx_valid, rx_byte, tx_busy,
        output rdy, state, rcv_data, tx_start, tx_data, baud_div,
               tx_empty, tx_overflow, rx_overrun
    );

    modport master (
        output uartc, cmd_data, rx_valid, rx_byte, tx_busy,
        input  rdy, state, rcv_data, tx_start, tx_data, baud_div,
               tx_empty, tx_overflow, rx_overrun
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Maps control-unit UART commands (RCV/SND/BAUD) onto the TX/RX engines: RCV stall FSM with a
// one-byte RX holding register, SND byte FIFO with paced drain, and the baud divisor register.
module uart_cmd_sequencer #(
    parameter int          TX_DEPTH   = 4,
    parameter logic [15:0] BAUD_RESET = 16'd434
) (
    input logic             clk,
    input logic             reset_n,
    uart_cmd_sequencer_if.slave bus
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(TX_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [2:0] CMD_RCV = 3'b010, CMD_SND = 3'b011, CMD_BAUD = 3'b100;

    typedef enum logic [1:0] {IDLE, RX_WAIT, RX_DONE} rx_state_t;
    rx_state_t cur, nxt;

    logic        rcv_cmd, take_hold, take_rx;
    logic        hold_full, rx_overrun_q;
    logic [7:0]  hold_byte;
    logic [31:0] rcv_q;
    logic        unused_cmd_hi;

    assign rcv_cmd       = (bus.uartc == CMD_RCV);
    assign unused_cmd_hi = ^bus.cmd_data[31:16];

    // take_hold / take_rx mark the cycle the FSM consumes a byte, i.e. the transition into RX_DONE
    always_comb begin
        nxt       = cur;
        take_hold = 1'b0;
        take_rx   = 1'b0;
        case (cur)
            IDLE: begin
                if (rcv_cmd) begin
                    if (hold_full) begin
                        nxt       = RX_DONE;
                        take_hold = 1'b1;
                    end else begin
                        nxt = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (!rcv_cmd) begin
                    nxt = IDLE;
                end else if (hold_full) begin
                    // byte landed in the holding register on the IDLE->RX_WAIT cycle
                    nxt       = RX_DONE;
                    take_hold = 1'b1;
                end else if (bus.rx_valid) begin
                    nxt     = RX_DONE;
                    take_rx = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= IDLE;
        else          cur <= nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full    <= 1'b0;
            hold_byte    <= 8'h00;
            rx_overrun_q <= 1'b0;
            rcv_q        <= 32'h0;
        end else begin
            if (bus.rx_valid && !take_rx) begin
                if (!hold_full || take_hold) begin
                    hold_full <= 1'b1;
                    hold_byte <= bus.rx_byte;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (take_hold) begin
                hold_full <= 1'b0;
            end
            if (take_hold)    rcv_q <= {24'h0, hold_byte};
            else if (take_rx) rcv_q <= {24'h0, bus.rx_byte};
        end
    end

    assign bus.rdy        = (cur != IDLE);
    assign bus.state      = (cur == RX_WAIT);
    assign bus.rcv_data   = rcv_q;
    assign bus.rx_overrun = rx_overrun_q;

    logic [7:0]    mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          start_q, overflow_q, push, push_ok, pop, full, empty;
    logic [7:0]    data_q;
    logic [15:0]   baud_q;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    // Start is combinational so a push at N can launch at N+1; start_q spaces the pulses apart
    assign pop     = !empty && !bus.tx_busy && !start_q;
    assign push    = (bus.uartc == CMD_SND);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.cmd_data[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            start_q    <= 1'b0;
            data_q     <= 8'h00;
            overflow_q <= 1'b0;
            baud_q     <= BAUD_RESET;
        end else begin
            start_q <= pop;
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                data_q <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && !push_ok) overflow_q <= 1'b1;
            if (bus.uartc == CMD_BAUD)
                baud_q <= (bus.cmd_data[15:0] == 16'h0) ? 16'h1 : bus.cmd_data[15:0];
        end
    end

    assign bus.tx_start    = pop;
    assign bus.tx_data     = pop ? mem[rd_ptr] : data_q;
    assign bus.tx_empty    = empty;
    assign bus.tx_overflow = overflow_q;
    assign bus.baud_div    = baud_q;
endmodule
